// File: rtl/tape_pkg.sv
// tape_pkg: shared decoder states and CSW image constants for the tape player
package tape_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_FETCH, S_LONG0, S_LONG1, S_LONG2, S_LONG3, S_COUNT, S_END
  } tape_state_t;
  localparam int PAUSE_GUARD  = 100;
  localparam int CSW_HDR_LEN  = 32;
  localparam int CSW_RATE_OFS = 25;
endpackage

// File: rtl/tape_fifo.sv
// tape_fifo: show-ahead sync FIFO; ports clk_sys/reset_n, flush, push/wdata, pop/rdata, full, empty, free
module tape_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     free
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full  = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign free  = (AW+1)'(DEPTH) - (wp - rp);
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk_sys)
    if (push && !full) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/tape_csw_player.sv
// tape_csw_player: CSW tape player; fetches the image via rd_req/rd_ack/addr/din into a FIFO,
// decodes pulse lengths and toggles audio_out from a fractional NCO clocked by ce.
// Controls: key_play, key_pause, tape_motor, tape_ready (low = eject), tape_size.
// Status: active, available, underrun (sticky), eof (pulse), pos (bytes decoded).
// Define TAPE_CSW_LOOP_EN to restart at the first pulse instead of stopping at end of image.
module tape_csw_player
  import tape_pkg::*;
#(
  parameter int CLOCK      = 48000000,
  parameter int ADDR_W     = 25,
  parameter int FIFO_DEPTH = 8,
  parameter int HDR_LEN    = CSW_HDR_LEN,
  parameter int RATE_OFS   = CSW_RATE_OFS
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              key_play,
  input  logic              key_pause,
  input  logic              tape_motor,
  input  logic              tape_ready,
  input  logic [ADDR_W-1:0] tape_size,
  output logic              rd_req,
  input  logic              rd_ack,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        din,
  output logic              audio_out,
  output logic              active,
  output logic              available,
  output logic              underrun,
  output logic              eof,
  output logic [ADDR_W-1:0] pos
);
  localparam int FW = $clog2(FIFO_DEPTH);
  tape_state_t state;
  logic [ADDR_W-1:0] size, rp, rofs;
  logic [31:0] rate, count, long_cnt;
  logic [32:0] acc, acc_sum;
  logic [7:0] f_data;
  logic [FW:0] f_free;
  logic [1:0] lidx;
  logic f_full, f_empty, push, pop, fetch_ok, nco_tick;
  logic rdy_q, play_q, pause_q, motor_q, paused, go, stop;
  assign push      = rd_req && rd_ack && !f_full;
  assign pop       = !f_empty && state inside {S_HDR, S_FETCH, S_LONG0, S_LONG1, S_LONG2, S_LONG3};
  assign fetch_ok  = !(state inside {S_IDLE, S_END}) && rp < size && f_free != '0;
  assign acc_sum   = acc + {1'b0, rate};
  assign nco_tick  = acc_sum >= 33'(CLOCK);
  assign rofs      = pos - ADDR_W'(RATE_OFS);
  assign lidx      = 2'(state - S_LONG0);
  assign long_cnt  = {f_data, count[23:0]};
  // pausing near the end is refused so a tape can never be parked on its final pulses
  assign go        = ce && ((tape_motor && !motor_q) || (key_play && !play_q));
  assign stop      = ce && ((motor_q && !tape_motor) || (key_pause && !pause_q)) &&
                     size - pos > ADDR_W'(PAUSE_GUARD);
  assign addr      = rp;
  assign active    = !paused && state inside {S_FETCH, S_LONG0, S_LONG1, S_LONG2, S_LONG3, S_COUNT};
  assign available = !(state inside {S_IDLE, S_END});
  tape_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk_sys, .reset_n, .flush(!tape_ready), .push, .pop, .wdata(din),
    .rdata(f_data), .full(f_full), .empty(f_empty), .free(f_free)
  );
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      {rdy_q, play_q, pause_q, motor_q} <= '0;
    end else begin
      rdy_q <= tape_ready;
      if (ce) {play_q, pause_q, motor_q} <= {key_play, key_pause, tape_motor};
    end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE; size <= '0; rp <= '0; pos <= '0; rate <= '0; count <= '0; acc <= '0;
      audio_out <= 1'b1; rd_req <= 1'b0; paused <= 1'b1; underrun <= 1'b0; eof <= 1'b0;
    end else if (!tape_ready) begin
      state <= S_IDLE; size <= '0; rp <= '0; pos <= '0; rate <= '0; count <= '0; acc <= '0;
      audio_out <= 1'b1; rd_req <= 1'b0; paused <= 1'b1; underrun <= 1'b0; eof <= 1'b0;
    end else begin
      eof <= 1'b0;
      if (!rdy_q) begin
        size     <= tape_size;
        rp       <= '0;
        underrun <= 1'b0;
        state    <= tape_size > ADDR_W'(HDR_LEN) ? S_HDR : S_IDLE;
      end
      if (push) begin
        rd_req <= 1'b0;
        rp     <= rp + 1'b1;
      end else if (!rd_req && fetch_ok) begin
        rd_req <= 1'b1;
      end
      if (stop) paused <= 1'b1;
      else if (go) paused <= 1'b0;
      if (pop) pos <= pos + 1'b1;
      case (state)
        S_HDR: if (pop) begin
          if (rofs < ADDR_W'(4)) rate[{rofs[1:0], 3'b000} +: 8] <= f_data;
          if (pos == ADDR_W'(HDR_LEN - 1)) state <= S_FETCH;
        end
        S_FETCH: if (pop) begin
          if (f_data != 8'd0) begin
            count     <= {24'd0, f_data};
            audio_out <= !audio_out;
            state     <= S_COUNT;
          end else begin
            state <= S_LONG0;
          end
        end else if (rp == size) begin
          eof <= 1'b1;
`ifdef TAPE_CSW_LOOP_EN
          rp    <= ADDR_W'(HDR_LEN);
          pos   <= ADDR_W'(HDR_LEN);
          state <= S_FETCH;
`else
          state <= S_END;
`endif
        end else begin
          underrun <= 1'b1;
        end
        S_LONG0, S_LONG1, S_LONG2, S_LONG3: if (pop) begin
          if (state == S_LONG3) begin
            count     <= long_cnt == 32'd0 ? 32'd1 : long_cnt;
            audio_out <= !audio_out;
            state     <= S_COUNT;
          end else begin
            count[{lidx, 3'b000} +: 8] <= f_data;
            state <= tape_state_t'(state + 4'd1);
          end
        end else if (rp != size) begin
          underrun <= 1'b1;
        end
        // acc carries its remainder across pulses so the long-run rate stays exact
        S_COUNT: if (ce && !paused) begin
          acc <= nco_tick ? acc_sum - 33'(CLOCK) : acc_sum;
          if (nco_tick) begin
            count <= count - 32'd1;
            if (count == 32'd1) state <= S_FETCH;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_tape_csw_player.sv
// tb_tape_csw_player: directed checks of the CSW tape player against hand-computed timings
module tb_tape_csw_player;
  localparam int CLK_HZ = 4410000;
`ifdef TAPE_CSW_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  logic clk_sys = 1'b0, reset_n = 1'b0, ce = 1'b1;
  logic key_play = 1'b0, key_pause = 1'b0, tape_motor = 1'b0, tape_ready = 1'b0;
  logic [24:0] tape_size = '0, addr, pos;
  logic rd_req, rd_ack = 1'b0;
  logic [7:0] din = 8'd0;
  logic audio_out, active, available, underrun, eof;
  logic [7:0] mem [1024];
  int vectors = 0, miscompares = 0;
  int ack_delay = 0, wait_cnt = 0;
  int cyc = 0, toggles = 0, t_last = 0, t_prev = 0, base = 0;
  logic audio_q = 1'b1;

  tape_csw_player #(.CLOCK(CLK_HZ)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .key_play(key_play), .key_pause(key_pause),
    .tape_motor(tape_motor), .tape_ready(tape_ready), .tape_size(tape_size), .rd_req(rd_req),
    .rd_ack(rd_ack), .addr(addr), .din(din), .audio_out(audio_out), .active(active),
    .available(available), .underrun(underrun), .eof(eof), .pos(pos)
  );

  always #5 clk_sys = ~clk_sys;

  // memory responder: acks ack_delay cycles after it sees rd_req
  always @(posedge clk_sys) begin
    cyc <= cyc + 1;
    if (rd_ack) rd_ack <= 1'b0;
    else if (!rd_req) wait_cnt <= 0;
    else if (wait_cnt >= ack_delay) begin
      rd_ack   <= 1'b1;
      din      <= mem[addr[9:0]];
      wait_cnt <= 0;
    end else wait_cnt <= wait_cnt + 1;
  end

  // toggle monitor: t_last holds the edge index at which audio_out changed
  always @(posedge clk_sys) begin
    if (audio_out !== audio_q) begin
      toggles <= toggles + 1;
      t_prev  <= t_last;
      t_last  <= cyc;
    end
    audio_q <= audio_out;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, required finish within 100000 cycles");
    $fatal(1, "timeout");
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_toggle(string tag, int b, int limit);
    int n = 0;
    while (toggles == b && n < limit) begin tick(); n++; end
    check(tag, toggles, b + 1);
  endtask

  task automatic wait_eof(string tag, int limit);
    int n = 0;
    while (eof !== 1'b1 && n < limit) begin tick(); n++; end
    check(tag, eof, 1);
  endtask

  task automatic set_header(int rate);
    for (int i = 0; i < 32; i++) mem[i] = 8'd0;
    for (int i = 0; i < 4; i++) mem[25 + i] = 8'(rate >> (8 * i));
  endtask

  task automatic load(int sz);
    tape_ready = 1'b0;
    tick(2);
    tape_size  = 25'(sz);
    tape_ready = 1'b1;
    tick();
  endtask

  task automatic press(logic play, logic pause);
    key_play  = play;
    key_pause = pause;
    tick();
    key_play  = 1'b0;
    key_pause = 1'b0;
    tick();
  endtask

  initial begin
    tick(2);
    check("rst_audio", audio_out, 1);
    check("rst_rd_req", rd_req, 0);
    check("rst_addr", addr, 0);
    check("rst_pos", pos, 0);
    check("rst_active", active, 0);
    check("rst_available", available, 0);
    check("rst_underrun", underrun, 0);
    check("rst_eof", eof, 0);
    reset_n = 1'b1;
    tick(2);

    // image no larger than the header never starts
    set_header(44100);
    load(32);
    tick(5);
    check("hdr_only_available", available, 0);
    check("hdr_only_rd_req", rd_req, 0);

    // 44100 Hz in a 4.41 MHz ce domain: 100 ce per sample; +1 cycle for the fetch pop
    mem[32] = 8'h0A;
    mem[33] = 8'h05;
    load(34);
    check("t1_available", available, 1);
    check("t1_underrun_clr", underrun, 0);
    press(1'b1, 1'b0);
    base = toggles;
    wait_toggle("t1_first", base, 400);
    wait_toggle("t1_second", base + 1, 1100);
    check("t1_len_0a", t_last - t_prev, 1001);
    wait_eof("t1_eof", 700);
    check("t1_eof_time", cyc - t_last, 501);
    tick();
    check("t1_eof_pulse", eof, 0);
    check("t1_available_end", available, LOOP);
    check("t1_active_end", active, LOOP);
    check("t1_audio_end", audio_out, 1);
    check("t1_pos_end", pos, LOOP ? 32 : 34);

    // escaped counts at 1 ce per sample: 259 (LE order), 0 -> 1, then 1000000
    set_header(CLK_HZ);
    for (int i = 0; i < 15; i++) mem[32 + i] = 8'h00;
    mem[33] = 8'h03; mem[34] = 8'h01;
    mem[43] = 8'h40; mem[44] = 8'h42; mem[45] = 8'h0F;
    load(47);
    press(1'b1, 1'b0);
    base = toggles;
    wait_toggle("t2_first", base, 400);
    wait_toggle("t2_second", base + 1, 400);
    check("t2_len_259", t_last - t_prev, 264);
    wait_toggle("t2_third", base + 2, 50);
    check("t2_len_zero", t_last - t_prev, 6);
    tick(2000);
    check("t2_long_hold", toggles, base + 3);
    check("t2_active", active, 1);
    check("t2_pos", pos, 47);
    check("t2_audio", audio_out, 0);
    check("t2_rd_req_idle", rd_req, 0);

    // eject mid-pulse
    tape_ready = 1'b0;
    tick();
    check("t6_audio", audio_out, 1);
    check("t6_rd_req", rd_req, 0);
    check("t6_addr", addr, 0);
    check("t6_pos", pos, 0);
    check("t6_active", active, 0);
    check("t6_available", available, 0);
    check("t6_underrun", underrun, 0);
    check("t6_eof", eof, 0);

    // slow memory starves the decoder
    ack_delay = 200;
    set_header(CLK_HZ);
    mem[32] = 8'd1; mem[33] = 8'd2; mem[34] = 8'd1;
    mem[35] = 8'd3; mem[36] = 8'd1; mem[37] = 8'd2;
    load(38);
    press(1'b1, 1'b0);
    base = toggles;
    wait_eof("t3_eof", 12000);
    check("t3_underrun", underrun, 1);
    check("t3_toggles", toggles - base, 6);
    check("t3_pos", pos, LOOP ? 32 : 38);
    check("t3_audio", audio_out, 1);
    ack_delay = 0;

    // pause with 500 bytes left freezes the NCO
    set_header(CLK_HZ);
    for (int i = 32; i < 533; i++) mem[i] = 8'd100;
    load(533);
    check("t4_underrun_clr", underrun, 0);
    press(1'b1, 1'b0);
    base = toggles;
    wait_toggle("t4_first", base, 400);
    press(1'b0, 1'b1);
    check("t4_paused", active, 0);
    tick(300);
    check("t4_frozen", toggles, base + 1);
    check("t4_audio_held", audio_out, 0);
    check("t4_pos_held", pos, 33);
    press(1'b1, 1'b0);
    wait_toggle("t4_resume", base + 1, 150);
    press(1'b1, 1'b1);
    check("t4_pause_wins", active, 0);

    // pause with only 50 bytes left is ignored
    load(83);
    press(1'b1, 1'b0);
    base = toggles;
    wait_toggle("t4b_first", base, 400);
    press(1'b0, 1'b1);
    check("t4b_still_active", active, 1);
    wait_toggle("t4b_second", base + 1, 150);
    check("t4b_len", t_last - t_prev, 101);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
